// File: rtl/atm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : atm_pkg
//  Description : Shared constants, FSM state type and helpers for the ATM
//                cell scheduling blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package atm_pkg;

    localparam int ATM_CELL_BYTES = 53;
    localparam int ATM_BYTE_W     = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } sched_state_t;

    // Index width for an N-entry one-hot vector, never narrower than 1 bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin priority select. Searches the
//                eligible vector upward from rr_ptr_i with wrap-around and
//                returns the first hit as one-hot grant plus index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import atm_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int IDX_W   = idx_width(N_PORTS)
) (
    input  logic [N_PORTS-1:0] eligible_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [N_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    // First eligible requester at or after the pointer wins.
    always_comb begin
        int cand;
        cand  = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int off = 0; off < N_PORTS; off++) begin
            cand = int'(rr_ptr_i) + off;
            if (cand >= N_PORTS) begin
                cand = cand - N_PORTS;
            end
            if (!any_o && eligible_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IDX_W'(cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/atm_cell_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : atm_cell_scheduler
//  Description : Round-robin scheduler sharing one byte-wide cell bus among
//                N_PORTS ingress ports. Grants a port holding a complete cell,
//                streams CELL_BYTES bytes with backpressure, then re-arbitrates.
//                A requester that drops out mid-cell aborts the cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module atm_cell_scheduler
    import atm_pkg::*;
#(
    parameter int N_PORTS    = 4,
    parameter int CELL_BYTES = ATM_CELL_BYTES,
    parameter int BYTE_W     = ATM_BYTE_W,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_PORTS-1:0]        port_en,
    input  logic [N_PORTS-1:0]        req,
    input  logic [N_PORTS*BYTE_W-1:0] port_data,
    output logic [N_PORTS-1:0]        rd_en,
    output logic [N_PORTS-1:0]        gnt,
    output logic [BYTE_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sof,
    output logic                      out_eof,
    output logic                      abort,
    output logic [CNT_W-1:0]          cells_sent
);

    localparam int IDX_W = idx_width(N_PORTS);
    localparam int BC_W  = $clog2(CELL_BYTES);

    sched_state_t         state_q;
    logic [N_PORTS-1:0]   gnt_q;
    logic [IDX_W-1:0]     gnt_idx_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [BC_W-1:0]      byte_cnt_q;
    logic [CNT_W-1:0]     cells_sent_q;
    logic                 abort_q;

    logic [N_PORTS-1:0]   eligible;
    logic [N_PORTS-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic                 in_xfer;
    logic                 last_byte;
    logic                 abort_now;
    logic                 take;
    logic [IDX_W-1:0]     rr_after_gnt;

    assign eligible = req & port_en;

    rr_arbiter #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .eligible_i (eligible),
        .rr_ptr_i   (rr_ptr_q),
        .gnt_o      (arb_gnt),
        .idx_o      (arb_idx),
        .any_o      (arb_any)
    );

    // Datapath and handshake decode for the granted port. The final byte
    // tolerates req dropping in the same cycle it is accepted, since the
    // port has then legitimately emptied its cell.
    always_comb begin
        in_xfer      = (state_q == XFER);
        last_byte    = (byte_cnt_q == BC_W'(CELL_BYTES - 1));
        abort_now    = in_xfer &&
                       (!port_en[gnt_idx_q] ||
                        (!req[gnt_idx_q] && !(last_byte && out_ready)));
        out_valid    = in_xfer && !abort_now;
        take         = out_valid && out_ready;
        out_data     = port_data[gnt_idx_q*BYTE_W +: BYTE_W];
        out_sof      = out_valid && (byte_cnt_q == '0);
        out_eof      = out_valid && last_byte;
        rd_en        = '0;
        rd_en[gnt_idx_q] = take;
        rr_after_gnt = (gnt_idx_q == IDX_W'(N_PORTS - 1)) ? '0
                                                         : gnt_idx_q + IDX_W'(1);
    end

    // Grant / transfer state machine with cell counter and abort pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            gnt_idx_q    <= '0;
            rr_ptr_q     <= '0;
            byte_cnt_q   <= '0;
            cells_sent_q <= '0;
            abort_q      <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        gnt_q      <= arb_gnt;
                        gnt_idx_q  <= arb_idx;
                        byte_cnt_q <= '0;
                        state_q    <= XFER;
                    end
                end
                XFER: begin
                    if (abort_now) begin
                        abort_q    <= 1'b1;
                        gnt_q      <= '0;
                        rr_ptr_q   <= rr_after_gnt;
                        byte_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else if (take) begin
                        if (last_byte) begin
                            cells_sent_q <= cells_sent_q + CNT_W'(1);
                            gnt_q        <= '0;
                            rr_ptr_q     <= rr_after_gnt;
                            byte_cnt_q   <= '0;
                            state_q      <= IDLE;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BC_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign abort      = abort_q;
    assign cells_sent = cells_sent_q;

endmodule
`default_nettype wire
